// File: rtl/cpu7_ifu_dec_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular FIFO between the
// fetch datapath and the decoder. It provides valid/ready handshakes on both
// sides, a flush, and an occupancy count. The decoder reads the head entry
// combinationally. A pending interrupt is merged into the head entry's
// exception fields on the way out; the stored entry itself is never changed.
module cpu7_ifu_dec_queue #(
    parameter int          GRLEN   = 32,
    parameter int          DEPTH   = 4,
    parameter int          HINT_W  = 4,
    parameter logic [5:0]  EXC_INT = 6'd0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [GRLEN-1:0]              in_pc,
    input  logic [31:0]                   in_inst,
    input  logic [GRLEN-3:0]              in_br_target,
    input  logic                          in_br_taken,
    input  logic                          in_exception,
    input  logic [5:0]                    in_exccode,
    input  logic [HINT_W-1:0]             in_hint,
    input  logic                          int_except,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [GRLEN-1:0]              out_pc,
    output logic [31:0]                   out_inst,
    output logic [GRLEN-3:0]              out_br_target,
    output logic                          out_br_taken,
    output logic                          out_exception,
    output logic [5:0]                    out_exccode,
    output logic [HINT_W-1:0]             out_hint,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Packed entry layout: {pc, inst, br_target, br_taken, exception, exccode, hint}
    localparam int EW = GRLEN + 32 + (GRLEN - 2) + 1 + 1 + 6 + HINT_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] rp_reg;
    logic [PW-1:0] wp_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [EW-1:0] entry_q [DEPTH];
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head;
    logic          clr;
    logic          push;
    logic          pop;

    assign in_ready  = (count_reg != FULL);
    assign out_valid = (count_reg != '0);
    assign count     = count_reg;

    // Reset and flush share one path; either voids any handshake in that cycle.
    assign clr  = rst | flush;
    assign push = in_valid & in_ready & ~clr;
    assign pop  = out_valid & out_ready & ~clr;

    assign in_entry = {in_pc, in_inst, in_br_target, in_br_taken,
                       in_exception, in_exccode, in_hint};

    // One storage register per slot, written only when the write pointer selects it.
    // Storage is deliberately left out of reset: out_valid masks stale contents.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
        logic [EW-1:0] entry_reg;

        // Capture the incoming instruction into this slot on an accepted push.
        always_ff @(posedge clk) begin
            if (push && (wp_reg == PW'(gi))) begin
                entry_reg <= in_entry;
            end
        end

        assign entry_q[gi] = entry_reg;
    end

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clr) begin
            rp_reg    <= '0;
            wp_reg    <= '0;
            count_reg <= '0;
        end else begin
            if (push) wp_reg <= wp_reg + 1'b1;
            if (pop)  rp_reg <= rp_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    assign head = entry_q[rp_reg];

    // Head presentation: zero when empty, otherwise the head entry with the interrupt merged in.
    always_comb begin
        out_pc        = '0;
        out_inst      = '0;
        out_br_target = '0;
        out_br_taken  = 1'b0;
        out_exception = 1'b0;
        out_exccode   = 6'd0;
        out_hint      = '0;
        if (out_valid) begin
            out_pc        = head[EW-1 -: GRLEN];
            out_inst      = head[EW-GRLEN-1 -: 32];
            out_br_target = head[EW-GRLEN-33 -: GRLEN-2];
            out_br_taken  = head[HINT_W+7];
            out_exception = head[HINT_W+6] | int_except;
            if (int_except) begin
                out_exccode = EXC_INT;
            end else if (head[HINT_W+6]) begin
                out_exccode = head[HINT_W+5 -: 6];
            end
            out_hint      = head[HINT_W-1:0];
        end
    end

endmodule

// File: tb/tb_cpu7_ifu_dec_queue.sv
// Bench for cpu7_ifu_dec_queue: directed scenarios followed by random traffic.
// A reference queue of expected entries is kept alongside the DUT, and a
// negedge monitor compares the presented head, count and handshakes against it.
module tb_cpu7_ifu_dec_queue;

    localparam int         GRLEN   = 32;
    localparam int         DEPTH   = 4;
    localparam int         HINT_W  = 4;
    localparam logic [5:0] EXC_INT = 6'd0;

    typedef struct {
        logic [GRLEN-1:0]  pc;
        logic [31:0]       inst;
        logic [GRLEN-3:0]  tgt;
        logic              taken;
        logic              exc;
        logic [5:0]        code;
        logic [HINT_W-1:0] hint;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [GRLEN-1:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic [GRLEN-3:0] in_br_target = '0;
    logic in_br_taken = 1'b0;
    logic in_exception = 1'b0;
    logic [5:0] in_exccode = '0;
    logic [HINT_W-1:0] in_hint = '0;
    logic int_except = 1'b0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [GRLEN-1:0] out_pc;
    logic [31:0] out_inst;
    logic [GRLEN-3:0] out_br_target;
    logic out_br_taken;
    logic out_exception;
    logic [5:0] out_exccode;
    logic [HINT_W-1:0] out_hint;
    logic [$clog2(DEPTH):0] count;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    ent_t sb[$];

    cpu7_ifu_dec_queue #(
        .GRLEN(GRLEN), .DEPTH(DEPTH), .HINT_W(HINT_W), .EXC_INT(EXC_INT)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_br_target(in_br_target),
        .in_br_taken(in_br_taken), .in_exception(in_exception),
        .in_exccode(in_exccode), .in_hint(in_hint),
        .int_except(int_except),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_br_target(out_br_target),
        .out_br_taken(out_br_taken), .out_exception(out_exception),
        .out_exccode(out_exccode), .out_hint(out_hint),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields(input logic [GRLEN-1:0] pc);
        in_pc        = pc;
        in_inst      = $urandom;
        in_br_target = GRLEN'($urandom) >> 2;
        in_br_taken  = 1'($urandom);
        in_exception = ($urandom_range(0, 3) == 0);
        in_exccode   = 6'($urandom);
        in_hint      = HINT_W'($urandom);
    endtask

    // Reference model: the queue contents follow the handshake rules at each edge.
    always @(posedge clk) begin
        ent_t e;
        int n;
        n = sb.size();
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_ready && n != 0) e = sb.pop_front();
            if (in_valid && n != DEPTH) begin
                e.pc = in_pc;   e.inst = in_inst; e.tgt = in_br_target;
                e.taken = in_br_taken; e.exc = in_exception;
                e.code = in_exccode;   e.hint = in_hint;
                sb.push_back(e);
            end
        end
    end

    // Monitor: compare everything the DUT presents against the model head.
    always @(negedge clk) begin
        ent_t h;
        if (mon_en) begin
            chk("count", 64'(count), 64'(sb.size()));
            chk("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                h = sb[0];
                chk("out_pc", 64'(out_pc), 64'(h.pc));
                chk("out_inst", 64'(out_inst), 64'(h.inst));
                chk("out_br_target", 64'(out_br_target), 64'(h.tgt));
                chk("out_br_taken", 64'(out_br_taken), 64'(h.taken));
                chk("out_hint", 64'(out_hint), 64'(h.hint));
                chk("out_exception", 64'(out_exception), 64'(h.exc | int_except));
                chk("out_exccode", 64'(out_exccode),
                    64'(int_except ? EXC_INT : (h.exc ? h.code : 6'd0)));
                if (out_ready && !rst && !flush)
                    $display("[TB] pop pc=%h inst=%h exc=%0d code=%h", out_pc, out_inst,
                             out_exception, out_exccode);
            end else begin
                chk("empty_pc", 64'(out_pc), 64'd0);
                chk("empty_inst", 64'(out_inst), 64'd0);
                chk("empty_tgt", 64'(out_br_target), 64'd0);
                chk("empty_taken", 64'(out_br_taken), 64'd0);
                chk("empty_hint", 64'(out_hint), 64'd0);
                chk("empty_exc", 64'(out_exception), 64'd0);
                chk("empty_code", 64'(out_exccode), 64'd0);
            end
        end
    end

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);

        // 1: fill the queue with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_fields(GRLEN'(32'h100 + 4 * i));
            in_valid = 1'b1;
            step();
            chk("t1_head_pc", 64'(out_pc), 64'h100);
        end
        in_valid = 1'b0;
        chk("t1_count", 64'(count), 64'd4);
        chk("t1_in_ready", 64'(in_ready), 64'd0);

        // 2: full queue refuses push even with a same-cycle pop
        rand_fields(GRLEN'(32'h110));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_count_after_pop", 64'(count), 64'd3);
        chk("t2_head_pc", 64'(out_pc), 64'h104);
        step();
        in_valid = 1'b0;
        chk("t2_count_after_push", 64'(count), 64'd4);

        // drain
        out_ready = 1'b1;
        repeat (4) step();
        chk("drain_count", 64'(count), 64'd0);

        // 3: continuous stream across pointer wrap
        for (int i = 0; i < 10; i++) begin
            rand_fields(GRLEN'(32'h200 + 4 * i));
            in_valid = 1'b1;
            step();
            chk("t3_count", 64'(count), 64'd1);
            chk("t3_pc", 64'(out_pc), 64'(32'h200 + 4 * i));
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;

        // 4: flush with a simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            rand_fields(GRLEN'(32'h280 + 4 * i));
            in_valid = 1'b1;
            step();
        end
        chk("t4_count_pre", 64'(count), 64'd3);
        rand_fields(GRLEN'(32'h300));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_out_pc", 64'(out_pc), 64'd0);
        step();
        chk("t4_no_ghost", 64'(count), 64'd0);

        // 5: interrupt merge
        rand_fields(GRLEN'(32'h400));
        in_exception = 1'b1;
        in_exccode   = 6'h08;
        in_valid     = 1'b1;
        step();
        in_valid   = 1'b0;
        int_except = 1'b1;
        #1;
        chk("t5_exc_int", 64'(out_exception), 64'd1);
        chk("t5_code_int", 64'(out_exccode), 64'(EXC_INT));
        int_except = 1'b0;
        #1;
        chk("t5_exc_base", 64'(out_exception), 64'd1);
        chk("t5_code_base", 64'(out_exccode), 64'h08);
        out_ready = 1'b1;
        step();
        out_ready  = 1'b0;
        int_except = 1'b1;
        #1;
        chk("t5_empty_exc", 64'(out_exception), 64'd0);
        chk("t5_empty_code", 64'(out_exccode), 64'd0);
        int_except = 1'b0;

        // 6: reset mid-operation with a push in progress
        for (int i = 0; i < 2; i++) begin
            rand_fields(GRLEN'(32'h500 + 4 * i));
            in_valid = 1'b1;
            step();
        end
        rand_fields(GRLEN'(32'h508));
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        chk("t6_out_pc", 64'(out_pc), 64'd0);
        chk("t6_out_inst", 64'(out_inst), 64'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rand_fields(GRLEN'($urandom));
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            int_except = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 32) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; int_except = 1'b0;
        step();
        @(negedge clk);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu7_ifu_dec_queue.md
Name: cpu7_ifu_dec_queue

Overview:
- Parametrised fetch-to-decode instruction queue. It replaces the single-entry, always-accepting fdp->dec pipeline register with a DEPTH-entry FIFO.
- Adds valid/ready backpressure, flush and an occupancy count.
- Sits between the fetch datapath (fdp) and the decoder/EXU issue port. The decoder reads the head entry combinationally.
- Interrupts are merged into the head entry's exception fields at dequeue.

Parameters:
- GRLEN, 32, architectural register/PC width.
- DEPTH, 4, number of queue entries. Must be a power of two, >= 2.
- HINT_W, 4, width of the branch-predictor hint field.
- EXC_INT, 6'd0, exccode reported for an interrupt.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all entries (branch redirect / exception)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept this cycle
- in_pc  in  GRLEN  instruction PC
- in_inst  in  32  instruction word
- in_br_target  in  GRLEN-2  predicted target (word address)
- in_br_taken  in  1  predicted taken
- in_exception  in  1  fetch-side exception
- in_exccode  in  6  fetch-side exception code
- in_hint  in  HINT_W  predictor hint
- int_except  in  1  pending interrupt, applied to the head entry
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes the head this cycle
- out_pc  out  GRLEN  head PC
- out_inst  out  32  head instruction
- out_br_target  out  GRLEN-2  head predicted target
- out_br_taken  out  1  head predicted taken
- out_exception  out  1  head exception, merged with the interrupt
- out_exccode  out  6  head exccode, merged with the interrupt
- out_hint  out  HINT_W  head hint
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Storage: circular buffer with read pointer rp and write pointer wp, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus the count register.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- in_ready = (count != DEPTH). It is combinational from count only; there is no path from out_ready. A full queue refuses a push even when a pop occurs in the same cycle.
- out_valid = (count != 0).
- No bypass: an entry pushed in cycle N is first visible at the outputs in cycle N+1. Minimum latency is 1 cycle.
- On push: write all in_* fields to entry[wp]; wp <= wp+1.
- On pop: rp <= rp+1.
- count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Data outputs (pc, inst, br_target, br_taken, hint, base exception, base exccode) reflect entry[rp] when out_valid=1. They are forced to 0 when out_valid=0.
- Exception merge, applied only when out_valid=1:
  - out_exception = entry.exception | int_except.
  - out_exccode priority: int_except ? EXC_INT : entry.exception ? entry.exccode : 6'd0.
  - The merge is combinational. Entry storage is never modified by int_except.
- flush:
  - Next cycle: rp=wp=0, count=0.
  - Takes priority over a same-cycle push and pop. Neither is performed, and the flushed-cycle handshake is void.
  - in_ready may still read 1 during the flush cycle. Fetch must not treat that transfer as accepted.
- rst:
  - Identical effect to flush.
  - Entry storage is not reset.
  - After reset: out_valid=0, in_ready=1, count=0, all data outputs 0, out_exception=int_except-independent 0.
  - Reset asserted mid-operation discards all entries on the next edge, regardless of handshakes.
- rst and flush both asserted: reset semantics, which are identical.
- Pointer wrap: after DEPTH pushes, wp returns to 0. Ordering is preserved across wrap, strictly FIFO.
- out_ready while empty: no effect. in_valid while full: no effect; fetch must hold its data.

Test Plan:
1. Reset, then push 4 entries (pc=0x100,0x104,0x108,0x10C) with out_ready=0 -> count=4, in_ready=0 on the following cycle, out_pc=0x100 from the cycle after the first push.
2. Full queue, in_valid=1 with pc=0x110, out_ready=1 for one cycle -> pop of 0x100, no push, count=3, then 0x110 accepted the next cycle.
3. Continuous push/pop for 10 entries (pc 0x200 + 4i) -> outputs are exactly in order across pointer wrap, count steady at 1, each entry appears 1 cycle after its push.
4. count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_pc=0; the flushed push never appears.
5. Head entry with in_exception=1, exccode=6'h08; int_except=1 -> out_exception=1, out_exccode=EXC_INT; int_except=0 -> out_exccode=6'h08; empty queue with int_except=1 -> out_exception=0.
6. Assert rst while count=2 and a push is in progress -> next cycle count=0, out_valid=0, in_ready=1, all outputs 0.
